// File: rtl/am2909_next_addr_ctrl.sv
// Next-address controller for cascaded Am2909 slices: opcode/condition decode, loop counter, stack depth.
// Latency: control outputs combinational in the same cycle; counter, depth and flags update on the clock edge.
// Backpressure: hold=1 idles the slices (PC recirculates) and freezes all state. Optional MSEQ_STACK_GUARD_EN.
module am2909_next_addr_ctrl #(
    parameter int CNT_W       = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       instr,
    input  logic             cc,
    input  logic             cc_en,
    input  logic             hold,
    input  logic [CNT_W-1:0] d_count,
    output logic             s1,
    output logic             s0,
    output logic             zero,
    output logic             cin,
    output logic             re,
    output logic             fe,
    output logic             pup,
    output logic             cnt_zero,
    output logic             stk_full,
    output logic             stk_empty,
    output logic [1:0]       stk_err
);

`ifdef MSEQ_STACK_GUARD_EN
    localparam int DW = $clog2(STACK_DEPTH + 1);
`else
    // Depth mirrors the 2909 pointer, which wraps modulo the stack depth.
    localparam int DW = $clog2(STACK_DEPTH);
`endif

    localparam logic [1:0] SRC_PC  = 2'b00;
    localparam logic [1:0] SRC_AR  = 2'b01;
    localparam logic [1:0] SRC_STK = 2'b10;
    localparam logic [1:0] SRC_D   = 2'b11;

    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    depth;
    logic             pass;
    logic             cnt_nz;
    logic [1:0]       op_src;
    logic             op_zero;
    logic             op_re;
    logic             push_req;
    logic             pop_req;
    logic             push_ok;
    logic             pop_ok;
    logic             dec;
    logic             load;
    logic             clr_depth;

    always_comb begin
        pass      = !cc_en | cc;
        cnt_nz    = (cnt != '0);
        op_src    = SRC_PC;
        op_zero   = 1'b1;
        op_re     = 1'b1;
        push_req  = 1'b0;
        pop_req   = 1'b0;
        dec       = 1'b0;
        load      = 1'b0;
        clr_depth = 1'b0;
        case (instr)
            4'd0: begin
                op_zero   = 1'b0;
                clr_depth = 1'b1;
            end
            4'd1: if (pass) begin
                op_src   = SRC_D;
                push_req = 1'b1;
            end
            4'd2: op_src = SRC_D;
            4'd3: if (pass) op_src = SRC_D;
            4'd4: begin
                push_req = 1'b1;
                load     = pass;
            end
            4'd5: begin
                push_req = 1'b1;
                op_src   = pass ? SRC_D : SRC_AR;
            end
            4'd6: if (pass) op_src = SRC_D;
            4'd7: op_src = pass ? SRC_D : SRC_AR;
            4'd8: if (cnt_nz) begin
                op_src = SRC_STK;
                dec    = 1'b1;
            end else begin
                pop_req = 1'b1;
            end
            4'd9: if (cnt_nz) begin
                op_src = SRC_D;
                dec    = 1'b1;
            end
            4'd10: if (pass) begin
                op_src  = SRC_STK;
                pop_req = 1'b1;
            end
            4'd11: if (pass) begin
                op_src  = SRC_D;
                pop_req = 1'b1;
            end
            4'd12: begin
                load  = 1'b1;
                op_re = 1'b0;
            end
            4'd13: if (pass) pop_req = 1'b1;
                   else      op_src  = SRC_STK;
            4'd14: op_src = SRC_PC;
            4'd15: if (pass) begin
                pop_req = 1'b1;
            end else if (cnt_nz) begin
                op_src = SRC_STK;
                dec    = 1'b1;
            end else begin
                op_src  = SRC_D;
                pop_req = 1'b1;
            end
            default: op_src = SRC_PC;
        endcase
    end

`ifdef MSEQ_STACK_GUARD_EN
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic [1:0] err;

    assign full    = (depth == DW'(STACK_DEPTH));
    assign empty   = (depth == '0);
    // Suppressed stack ops leave the source selection untouched.
    assign ovf     = push_req & full;
    assign unf     = pop_req & empty;
    assign push_ok = push_req & !full;
    assign pop_ok  = pop_req & !empty;

    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = err;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err <= 2'b00;
        end else if (!hold) begin
            err <= err | {ovf, unf};
        end
    end
`else
    assign push_ok   = push_req;
    assign pop_ok    = pop_req;
    assign stk_full  = 1'b0;
    assign stk_empty = 1'b0;
    assign stk_err   = 2'b00;
`endif

    assign cnt_zero = !cnt_nz;

    always_comb begin
        if (!reset_n) begin
            {s1, s0} = SRC_PC;
            zero     = 1'b0;
            cin      = 1'b0;
            re       = 1'b1;
            fe       = 1'b1;
            pup      = 1'b0;
        end else if (hold) begin
            {s1, s0} = SRC_PC;
            zero     = 1'b1;
            cin      = 1'b0;
            re       = 1'b1;
            fe       = 1'b1;
            pup      = 1'b0;
        end else begin
            {s1, s0} = op_src;
            zero     = op_zero;
            cin      = 1'b1;
            re       = op_re;
            fe       = !(push_ok | pop_ok);
            pup      = push_ok;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt   <= '0;
            depth <= '0;
        end else if (!hold) begin
            if (load) begin
                cnt <= d_count;
            end else if (dec && cnt_nz) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (clr_depth) begin
                depth <= '0;
            end else if (push_ok) begin
                depth <= depth + DW'(1);
            end else if (pop_ok) begin
                depth <= depth - DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_am2909_next_addr_ctrl.sv
// Bench for am2909_next_addr_ctrl: directed scenarios then random opcodes against a table-driven model.
module tb_am2909_next_addr_ctrl;
    localparam int CNT_W = 12;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [3:0]       instr;
    logic             cc;
    logic             cc_en;
    logic             hold;
    logic [CNT_W-1:0] d_count;
    logic             s1, s0, zero, cin, re, fe, pup;
    logic             cnt_zero, stk_full, stk_empty;
    logic [1:0]       stk_err;

    int checks   = 0;
    int failures = 0;

    // Per opcode: {pass source, pass stack op, fail source, fail stack op}
    // source 0 PC, 1 AR, 2 stack, 3 D; stack op 0 none, 1 push, 2 pop
    int tbl[16][4];

    int m_cnt, m_depth, m_err;
    int e_s, e_zero, e_cin, e_re, e_fe, e_pup;
    int n_cnt, n_depth, n_err;

    am2909_next_addr_ctrl #(.CNT_W(CNT_W), .STACK_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .instr(instr), .cc(cc), .cc_en(cc_en),
        .hold(hold), .d_count(d_count), .s1(s1), .s0(s0), .zero(zero), .cin(cin),
        .re(re), .fe(fe), .pup(pup), .cnt_zero(cnt_zero), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit pass;
        int src, stk, op;
        bit dec, load, ovf, unf;
        op   = int'(instr);
        pass = !cc_en || cc;
        n_cnt = m_cnt; n_depth = m_depth; n_err = m_err;
        e_pup = 0;
        if (!reset_n) begin
            e_s = 0; e_zero = 0; e_cin = 0; e_re = 1; e_fe = 1;
            n_cnt = 0; n_depth = 0; n_err = 0;
        end else if (hold) begin
            e_s = 0; e_zero = 1; e_cin = 0; e_re = 1; e_fe = 1;
        end else begin
            dec = 0;
            src = pass ? tbl[op][0] : tbl[op][2];
            stk = pass ? tbl[op][1] : tbl[op][3];
            if (op == 8) begin
                if (m_cnt != 0) begin src = 2; stk = 0; dec = 1; end
                else begin src = 0; stk = 2; end
            end else if (op == 9) begin
                src = (m_cnt != 0) ? 3 : 0; stk = 0; dec = (m_cnt != 0);
            end else if (op == 15) begin
                if (pass) begin src = 0; stk = 2; end
                else if (m_cnt != 0) begin src = 2; stk = 0; dec = 1; end
                else begin src = 3; stk = 2; end
            end
            load = (op == 12) || (op == 4 && pass);
            ovf = 0; unf = 0;
`ifdef MSEQ_STACK_GUARD_EN
            if (stk == 1 && m_depth == 4) begin stk = 0; ovf = 1; end
            if (stk == 2 && m_depth == 0) begin stk = 0; unf = 1; end
            n_err = m_err | (ovf ? 2 : 0) | (unf ? 1 : 0);
            if (stk == 1) n_depth = m_depth + 1;
            if (stk == 2) n_depth = m_depth - 1;
`else
            if (stk == 1) n_depth = (m_depth + 1) % 4;
            if (stk == 2) n_depth = (m_depth + 3) % 4;
`endif
            if (op == 0) n_depth = 0;
            if (load) n_cnt = int'(d_count);
            else if (dec && m_cnt > 0) n_cnt = m_cnt - 1;
            e_s = src; e_zero = (op == 0) ? 0 : 1; e_cin = 1;
            e_re = (op == 12) ? 0 : 1;
            e_fe = (stk == 0) ? 1 : 0;
            e_pup = (stk == 1) ? 1 : 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".s"}, 32'({s1, s0}), 32'(e_s));
        chk({tag, ".zero"}, 32'(zero), 32'(e_zero));
        chk({tag, ".cin"}, 32'(cin), 32'(e_cin));
        chk({tag, ".re"}, 32'(re), 32'(e_re));
        chk({tag, ".fe"}, 32'(fe), 32'(e_fe));
        if (e_fe == 0) chk({tag, ".pup"}, 32'(pup), 32'(e_pup));
        chk({tag, ".cnt_zero"}, 32'(cnt_zero), 32'(m_cnt == 0));
`ifdef MSEQ_STACK_GUARD_EN
        chk({tag, ".stk_full"}, 32'(stk_full), 32'(m_depth == 4));
        chk({tag, ".stk_empty"}, 32'(stk_empty), 32'(m_depth == 0));
        chk({tag, ".stk_err"}, 32'(stk_err), 32'(m_err));
`else
        chk({tag, ".stk_flags"}, 32'({stk_full, stk_empty, stk_err}), 32'(0));
`endif
    endtask

    // Apply inputs, settle, compare against the model, leave the clock edge to tick().
    task automatic drive(input string tag, input int op, input bit c, input bit ce,
                         input bit h, input int d, input bit rn);
        instr = 4'(op); cc = c; cc_en = ce; hold = h; d_count = CNT_W'(d); reset_n = rn;
        #2;
        model_eval();
        check_all(tag);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        m_cnt = n_cnt; m_depth = n_depth; m_err = n_err;
    endtask

    initial begin
        tbl = '{
            '{0, 0, 0, 0}, '{3, 1, 0, 0}, '{3, 0, 3, 0}, '{3, 0, 0, 0},
            '{0, 1, 0, 1}, '{3, 1, 1, 1}, '{3, 0, 0, 0}, '{3, 0, 1, 0},
            '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{2, 2, 0, 0}, '{3, 2, 0, 0},
            '{0, 0, 0, 0}, '{0, 2, 2, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}
        };
        m_cnt = 0; m_depth = 0; m_err = 0;
        reset_n = 1'b0; instr = 4'd14; cc = 1'b0; cc_en = 1'b0; hold = 1'b0; d_count = '0;
        @(posedge clock);
        #1;

        // Reset held for two edges
        drive("rst0", 5, 1, 0, 1, 7, 0); tick();
        drive("rst1", 1, 1, 0, 0, 3, 0);
        chk("rst.zero", 32'(zero), 0);
        chk("rst.cin", 32'(cin), 0);
        chk("rst.fe", 32'(fe), 1);
        chk("rst.cnt_zero", 32'(cnt_zero), 1);
        tick();

        // LDCT 3 then RPCT x4
        drive("ldct", 12, 0, 0, 0, 3, 1);
        chk("ldct.re", 32'(re), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive("rpct", 9, 0, 0, 0, 9, 1);
            chk("rpct.s", 32'({s1, s0}), (i < 3) ? 3 : 0);
            if (i == 3) chk("rpct.cnt_zero", 32'(cnt_zero), 1);
            tick();
        end

        // Five CJS passes from an empty stack
        drive("jz", 0, 0, 0, 0, 0, 1); tick();
        for (int i = 0; i < 5; i++) begin
            drive("cjs", 1, 1, 1, 0, 16 + i, 1);
            chk("cjs.s", 32'({s1, s0}), 3);
`ifdef MSEQ_STACK_GUARD_EN
            chk("cjs.fe", 32'(fe), (i < 4) ? 0 : 1);
            if (i == 4) chk("cjs.full", 32'(stk_full), 1);
`else
            chk("cjs.fe", 32'(fe), 0);
`endif
            tick();
        end
`ifdef MSEQ_STACK_GUARD_EN
        drive("cjs.after", 14, 0, 0, 0, 0, 1);
        chk("cjs.err", 32'(stk_err), 2);
        tick();
`endif

        // CRTN at depth 0, then CRTN failing
        drive("rst2", 14, 0, 0, 0, 0, 0); tick();
        drive("crtn.pass", 10, 0, 0, 0, 0, 1);
        chk("crtn.s", 32'({s1, s0}), 2);
`ifdef MSEQ_STACK_GUARD_EN
        chk("crtn.fe", 32'(fe), 1);
`endif
        tick();
        drive("crtn.fail", 10, 0, 1, 0, 0, 1);
        chk("crtn.fail.s", 32'({s1, s0}), 0);
        chk("crtn.fail.fe", 32'(fe), 1);
`ifdef MSEQ_STACK_GUARD_EN
        chk("crtn.err", 32'(stk_err), 1);
`endif
        tick();

        // Hold during RFCT with cnt=5
        drive("ldct5", 12, 0, 0, 0, 5, 1); tick();
        drive("rfct.hold", 8, 0, 0, 1, 0, 1);
        chk("rfct.hold.cin", 32'(cin), 0);
        chk("rfct.hold.s", 32'({s1, s0}), 0);
        tick();
        drive("rfct.run", 8, 0, 0, 0, 0, 1);
        chk("rfct.run.s", 32'({s1, s0}), 2);
        tick();
        for (int i = 0; i < 4; i++) begin drive("rfct.drain", 8, 0, 0, 0, 0, 1); tick(); end
        drive("rfct.end", 14, 0, 0, 0, 0, 1);
        chk("rfct.cnt_zero", 32'(cnt_zero), 1);
        tick();

        // TWB with cnt=0, failing condition, depth 1
        drive("jz2", 0, 0, 0, 0, 0, 1); tick();
        drive("cjs1", 1, 1, 1, 0, 2, 1); tick();
        drive("ldct0", 12, 0, 0, 0, 0, 1); tick();
        drive("twb", 15, 0, 1, 0, 0, 1);
        chk("twb.s", 32'({s1, s0}), 3);
        chk("twb.fe", 32'(fe), 0);
        chk("twb.pup", 32'(pup), 0);
        tick();
`ifdef MSEQ_STACK_GUARD_EN
        drive("twb.after", 14, 0, 0, 0, 0, 1);
        chk("twb.empty", 32'(stk_empty), 1);
        tick();
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive("rand", int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 39) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
